// File: rtl/cpu_pkg.sv
// Shared CPU constants: operand-select codes and data width used by the
// ALU input mux and the control decoder, plus N/Z pre-flag helpers.
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] MUX_A   = 2'b00;
    localparam logic [1:0] MUX_X   = 2'b01;
    localparam logic [1:0] MUX_Y   = 2'b10;
    localparam logic [1:0] MUX_MEM = 2'b11;

    // Negative pre-flag: sign bit of the operand.
    function automatic logic neg_of(input logic [DATA_W-1:0] v);
        return v[DATA_W-1];
    endfunction

    // Zero pre-flag: set when every operand bit is clear.
    function automatic logic zero_of(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_input_mux.sv
// Operand-select stage in front of the 6502 ALU: picks A/X/Y/data bus/SP,
// registers the byte and its N/Z pre-flags for transfer instructions.
module alu_input_mux #(
    parameter int                        DATA_W    = cpu_pkg::DATA_W,
    parameter logic [cpu_pkg::DATA_W-1:0] RESET_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mux_code,
    input  logic              sp_sel,
    input  logic [DATA_W-1:0] a_reg,
    input  logic [DATA_W-1:0] x_reg,
    input  logic [DATA_W-1:0] y_reg,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] out,
    output logic              neg,
    output logic              zero
);

    import cpu_pkg::*;

    logic [DATA_W-1:0] sel_s;
    logic [DATA_W-1:0] out_r;
    logic              neg_r;
    logic              zero_r;

    // Source select; the stack pointer overrides the encoded selection.
    always_comb begin
        sel_s = data_in;
        if (sp_sel) begin
            sel_s = sp;
        end else begin
            case (mux_code)
                MUX_A:   sel_s = a_reg;
                MUX_X:   sel_s = x_reg;
                MUX_Y:   sel_s = y_reg;
                MUX_MEM: sel_s = data_in;
                default: sel_s = data_in;
            endcase
        end
    end

    // Operand and pre-flags load together so all three always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r  <= RESET_VAL;
            neg_r  <= neg_of(RESET_VAL);
            zero_r <= zero_of(RESET_VAL);
        end else begin
            out_r  <= sel_s;
            neg_r  <= neg_of(sel_s);
            zero_r <= zero_of(sel_s);
        end
    end

    assign out  = out_r;
    assign neg  = neg_r;
    assign zero = zero_r;

endmodule

// File: tb/tb_alu_input_mux.sv
// Directed self-checking bench for alu_input_mux: reset, source sweep,
// SP override, zero/negative flags, source isolation and mid-run reset.
module tb_alu_input_mux;

    logic       clk;
    logic       rst;
    logic [1:0] mux_code;
    logic       sp_sel;
    logic [7:0] a_reg;
    logic [7:0] x_reg;
    logic [7:0] y_reg;
    logic [7:0] data_in;
    logic [7:0] sp;
    logic [7:0] out;
    logic       neg;
    logic       zero;

    int tests_run;
    int tests_failed;

    alu_input_mux dut (
        .clk      (clk),
        .rst      (rst),
        .mux_code (mux_code),
        .sp_sel   (sp_sel),
        .a_reg    (a_reg),
        .x_reg    (x_reg),
        .y_reg    (y_reg),
        .data_in  (data_in),
        .sp       (sp),
        .out      (out),
        .neg      (neg),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reg = 8'h5A; mux_code = 2'b00; sp_sel = 1'b0; rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h00, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got out=%h neg=%b zero=%b, want out=00 neg=0 zero=1", out, neg, zero);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h5A, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_release: got out=%h neg=%b zero=%b, want out=5a neg=0 zero=0", out, neg, zero);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_out [4];
        logic       exp_neg [4];
        exp_out = '{8'h11, 8'h22, 8'h33, 8'h84};
        exp_neg = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_reg = 8'h11; x_reg = 8'h22; y_reg = 8'h33; data_in = 8'h84; sp_sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mux_code = 2'(i);
            tick();
            tests_run++;
            if ({out, neg, zero} !== {exp_out[i], exp_neg[i], 1'b0}) begin
                tests_failed++;
                $display("FAIL sweep_code%0d: got out=%h neg=%b zero=%b, want out=%h neg=%b zero=0",
                         i, out, neg, zero, exp_out[i], exp_neg[i]);
            end
        end
    endtask

    task automatic test_sp_override();
        sp = 8'hFF; sp_sel = 1'b1; mux_code = 2'b10;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'hFF, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sp_override: got out=%h neg=%b zero=%b, want out=ff neg=1 zero=0", out, neg, zero);
        end
        sp_sel = 1'b0;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h33, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sp_release: got out=%h neg=%b zero=%b, want out=33 neg=0 zero=0", out, neg, zero);
        end
    endtask

    task automatic test_zero_flag();
        mux_code = 2'b01; x_reg = 8'h00;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h00, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL zero_flag: got out=%h neg=%b zero=%b, want out=00 neg=0 zero=1", out, neg, zero);
        end
        x_reg = 8'h80;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h80, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL neg_flag: got out=%h neg=%b zero=%b, want out=80 neg=1 zero=0", out, neg, zero);
        end
    endtask

    task automatic test_isolation();
        logic [7:0] exp_a;
        mux_code = 2'b00; sp_sel = 1'b0;
        for (int i = 0; i < 50; i++) begin
            exp_a   = 8'((i * 37 + 5) % 256);
            a_reg   = exp_a;
            x_reg   = 8'($urandom_range(255, 0));
            y_reg   = 8'($urandom_range(255, 0));
            data_in = 8'($urandom_range(255, 0));
            sp      = 8'($urandom_range(255, 0));
            tick();
            tests_run++;
            if ({out, neg, zero} !== {exp_a, exp_a[7], (exp_a == 8'h00)}) begin
                tests_failed++;
                $display("FAIL isolation_%0d: got out=%h neg=%b zero=%b, want out=%h neg=%b zero=%b",
                         i, out, neg, zero, exp_a, exp_a[7], (exp_a == 8'h00));
            end
        end
    endtask

    task automatic test_mid_reset();
        mux_code = 2'b00; sp_sel = 1'b0; a_reg = 8'hC3;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'hC3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_preload: got out=%h neg=%b zero=%b, want out=c3 neg=1 zero=0", out, neg, zero);
        end
        rst = 1'b1;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'h00, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL mid_reset: got out=%h neg=%b zero=%b, want out=00 neg=0 zero=1", out, neg, zero);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({out, neg, zero} !== {8'hC3, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reload: got out=%h neg=%b zero=%b, want out=c3 neg=1 zero=0", out, neg, zero);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        mux_code = 2'b00;
        sp_sel   = 1'b0;
        a_reg    = 8'h00;
        x_reg    = 8'h00;
        y_reg    = 8'h00;
        data_in  = 8'h00;
        sp       = 8'h00;
        test_reset();
        test_sweep();
        test_sp_override();
        test_zero_flag();
        test_isolation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
